// File: rtl/led_fade_pwm.sv
// -----------------------------------------------------------------------------
// led_fade_pwm
//
// Purpose:
//   Takes the one-hot rotating pattern from the LED flow generator and drives
//   the LED pins with a fading "comet tail". Each channel has a brightness
//   level. The level jumps to LVL_MAX while its pattern bit is 1. After the bit
//   clears, the level decays by one step per fade tick, stopping at 0. A
//   single free-running PWM counter is shared by all channels. Each channel
//   compares its duty value against that counter to produce its drive.
//
// Parameters:
//   DUTY_W   - width of per-channel level and PWM counter (LVL_MAX = 2^DUTY_W-1)
//   PWM_DIV  - sys_clk cycles per PWM tick (>= 1)
//   FADE_DIV - PWM ticks per fade step (>= 1)
//
// Ports:
//   sys_clk   in   1  system clock
//   sys_rst_n in   1  synchronous reset, active-low
//   pwm_en    in   1  1 = run, 0 = blank outputs and clear all state
//   led_in    in   8  LED pattern from the flow stage
//   led_pwm   out  8  registered PWM drive to the LED pins, active-high
//
// Build option:
//   LED_FADE_PWM_GAMMA_EN - when defined, each level is mapped through a
//   square-law curve, duty = (level*level) >> DUTY_W, before the compare.
//   LVL_MAX is pinned to full on. When the macro is undefined, duty equals
//   level and no multiplier is built.
// -----------------------------------------------------------------------------
module led_fade_pwm #(
  parameter int          DUTY_W   = 4,
  parameter logic [23:0] PWM_DIV  = 24'd2500,
  parameter logic [15:0] FADE_DIV = 16'd15
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pwm_en,
  input  logic [7:0] led_in,
  output logic [7:0] led_pwm
);

  localparam logic [DUTY_W-1:0] LVL_MAX  = {DUTY_W{1'b1}};
  // LVL_MAX-1: all ones except the LSB. The PWM counter wraps after this value.
  localparam logic [DUTY_W-1:0] PWM_LAST = {{(DUTY_W-1){1'b1}}, 1'b0};
  localparam logic [DUTY_W-1:0] DUTY_ONE = {{(DUTY_W-1){1'b0}}, 1'b1};
  localparam logic [23:0]       PRE_LAST = PWM_DIV - 24'd1;
  localparam logic [15:0]       FADE_LAST = FADE_DIV - 16'd1;

  // Saturating one-step decay: a level of 0 stays at 0 and never wraps.
  function automatic logic [DUTY_W-1:0] sat_dec(input logic [DUTY_W-1:0] lvl);
    if (lvl == '0) begin
      return '0;
    end
    return lvl - DUTY_ONE;
  endfunction

  // Maps a brightness level to the duty value used by the PWM compare.
  function automatic logic [DUTY_W-1:0] duty_map(input logic [DUTY_W-1:0] lvl);
`ifdef LED_FADE_PWM_GAMMA_EN
    logic [2*DUTY_W-1:0] sq;
    sq = {{DUTY_W{1'b0}}, lvl} * {{DUTY_W{1'b0}}, lvl};
    // Without this special case, LVL_MAX would map just short of full on.
    if (lvl == LVL_MAX) begin
      return LVL_MAX;
    end
    return DUTY_W'(sq >> DUTY_W);
`else
    return lvl;
`endif
  endfunction

  logic [23:0]       pre_cnt_p0;
  logic [DUTY_W-1:0] pwm_cnt_p0;
  logic [15:0]       fade_cnt_p0;
  logic [DUTY_W-1:0] level_p0 [8];
  logic [DUTY_W-1:0] level_nxt [8];
  logic [7:0]        pwm_p1;
  logic              pwm_tick;
  logic              fade_tick;
  logic              clr;

  // pwm_en low clears everything, exactly as reset does. Timing after
  // re-enable is therefore identical to timing after reset.
  assign clr       = !sys_rst_n || !pwm_en;
  assign pwm_tick  = (pre_cnt_p0 == PRE_LAST);
  assign fade_tick = pwm_tick && (fade_cnt_p0 == FADE_LAST);

  // ---- stage p0: prescaler, shared PWM counter, fade timebase ----
  always_ff @(posedge sys_clk) begin
    if (clr) begin
      pre_cnt_p0  <= '0;
      pwm_cnt_p0  <= '0;
      fade_cnt_p0 <= '0;
    end else begin
      if (pwm_tick) begin
        pre_cnt_p0 <= '0;
      end else begin
        pre_cnt_p0 <= pre_cnt_p0 + 24'd1;
      end

      if (pwm_tick) begin
        // The counter covers 0..LVL_MAX-1. With the strict ">" compare,
        // LVL_MAX is then always on and 0 is always off.
        if (pwm_cnt_p0 == PWM_LAST) begin
          pwm_cnt_p0 <= '0;
        end else begin
          pwm_cnt_p0 <= pwm_cnt_p0 + DUTY_ONE;
        end

        if (fade_cnt_p0 == FADE_LAST) begin
          fade_cnt_p0 <= '0;
        end else begin
          fade_cnt_p0 <= fade_cnt_p0 + 16'd1;
        end
      end
    end
  end

  // Per-channel level update. A load takes priority over a coincident decay.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      level_nxt[i] = level_p0[i];
      if (led_in[i]) begin
        level_nxt[i] = LVL_MAX;
      end else if (fade_tick) begin
        level_nxt[i] = sat_dec(level_p0[i]);
      end
    end
  end

  // ---- stage p0: brightness levels ----
  always_ff @(posedge sys_clk) begin
    if (clr) begin
      for (int i = 0; i < 8; i++) begin
        level_p0[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        level_p0[i] <= level_nxt[i];
      end
    end
  end

  // ---- stage p1: registered duty compare ----
  always_ff @(posedge sys_clk) begin
    if (clr) begin
      pwm_p1 <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        pwm_p1[i] <= (duty_map(level_p0[i]) > pwm_cnt_p0);
      end
    end
  end

  assign led_pwm = pwm_p1;

endmodule

// File: tb/tb_led_fade_pwm.sv
module tb_led_fade_pwm;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       pwm_en;
  logic [7:0] led_in;
  logic [7:0] led_pwm;

  int total;
  int bad;
  int e;        // edges since the last clearing edge (reset or disable)
  int hi [8];   // high clocks per channel in the last measured window

  led_fade_pwm #(
    .DUTY_W  (4),
    .PWM_DIV (24'd2),
    .FADE_DIV(16'd15)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .pwm_en   (pwm_en),
    .led_in   (led_in),
    .led_pwm  (led_pwm)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Expected duty for a level, as a hand-written table.
  function automatic int duty_of(input int lvl);
`ifdef LED_FADE_PWM_GAMMA_EN
    int tbl [16];
    tbl = '{0, 0, 0, 0, 1, 1, 2, 3, 4, 5, 6, 7, 9, 10, 12, 15};
    return tbl[lvl];
`else
    return lvl;
`endif
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
    e++;
  endtask

  task automatic tick_to(input int n);
    while (e < n) tick();
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    e = 0;
  endtask

  // Counts the high clocks on each channel over the next 30 edges.
  task automatic count_window();
    for (int b = 0; b < 8; b++) hi[b] = 0;
    repeat (30) begin
      tick();
      for (int b = 0; b < 8; b++) if (led_pwm[b]) hi[b]++;
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    pwm_en    = 1'b1;
    led_in    = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (led_pwm !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got %h want 00", i, led_pwm);
      end
    end
    sys_rst_n = 1'b1;
    e = 0;
    tick();
    total++;
    if (led_pwm !== 8'h00) begin
      bad++;
      $display("FAIL reset_edge1: got %h want 00", led_pwm);
    end
    tick();
    total++;
    if (led_pwm !== 8'hFF) begin
      bad++;
      $display("FAIL reset_edge2: got %h want ff", led_pwm);
    end
  endtask

  task automatic test_steady_on();
    int others;
    led_in = 8'h08;
    pwm_en = 1'b1;
    do_reset();
    tick_to(30);
    for (int k = 1; k <= 3; k++) begin
      count_window();
      others = 0;
      for (int b = 0; b < 8; b++) if (b != 3) others += hi[b];
      total++;
      if (hi[3] !== 30) begin
        bad++;
        $display("FAIL steady_bit3[%0d]: got %0d want 30", k, hi[3]);
      end
      total++;
      if (others !== 0) begin
        bad++;
        $display("FAIL steady_others[%0d]: got %0d want 0", k, others);
      end
    end
  endtask

  task automatic test_linear_fade();
    int lvl;
    led_in = 8'h01;
    do_reset();
    tick();
    led_in = 8'h00;
    tick_to(30);
    for (int k = 1; k <= 17; k++) begin
      count_window();
      lvl = (k <= 15) ? 15 - k : 0;
      total++;
      if (hi[0] !== 2 * duty_of(lvl)) begin
        bad++;
        $display("FAIL fade_win[%0d]: got %0d want %0d", k, hi[0], 2 * duty_of(lvl));
      end
    end
  endtask

  task automatic test_retrigger();
    led_in = 8'h01;
    do_reset();
    tick();
    led_in = 8'h00;
    tick_to(30);
    count_window();
    total++;
    if (hi[0] !== 2 * duty_of(14)) begin
      bad++;
      $display("FAIL retrig_pre: got %0d want %0d", hi[0], 2 * duty_of(14));
    end
    // Edge 90 carries a fade tick; the load must win.
    tick_to(89);
    led_in = 8'h01;
    tick();
    led_in = 8'h00;
    count_window();
    total++;
    if (hi[0] !== 30) begin
      bad++;
      $display("FAIL retrig_load: got %0d want 30", hi[0]);
    end
    count_window();
    total++;
    if (hi[0] !== 2 * duty_of(14)) begin
      bad++;
      $display("FAIL retrig_after: got %0d want %0d", hi[0], 2 * duty_of(14));
    end
  endtask

  task automatic test_enable_blank();
    int seen;
    led_in = 8'h01;
    do_reset();
    tick();
    led_in = 8'h00;
    tick_to(65);
    pwm_en = 1'b0;
    led_in = 8'h81;
    tick();
    total++;
    if (led_pwm !== 8'h00) begin
      bad++;
      $display("FAIL blank_first: got %h want 00", led_pwm);
    end
    seen = 0;
    repeat (4) begin
      tick();
      if (led_pwm !== 8'h00) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL blank_hold: got %0d nonzero edges want 0", seen);
    end
    pwm_en = 1'b1;
    led_in = 8'h00;
    e = 0;
    seen = 0;
    while (e < 60) begin
      tick();
      if (led_pwm !== 8'h00) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL reenable_dark: got %0d nonzero edges want 0", seen);
    end
    // The counters restarted from 0, so the fade tick lands on edge 90 again.
    led_in = 8'h01;
    tick();
    led_in = 8'h00;
    tick_to(90);
    count_window();
    total++;
    if (hi[0] !== 2 * duty_of(14)) begin
      bad++;
      $display("FAIL reenable_win3: got %0d want %0d", hi[0], 2 * duty_of(14));
    end
    count_window();
    total++;
    if (hi[0] !== 2 * duty_of(13)) begin
      bad++;
      $display("FAIL reenable_win4: got %0d want %0d", hi[0], 2 * duty_of(13));
    end
  endtask

  task automatic test_independent();
    led_in = 8'h01;
    do_reset();
    tick();
    led_in = 8'h00;
    tick_to(30);
    led_in = 8'h80;
    tick();
    led_in = 8'h00;
    tick_to(60);
    count_window();
    total++;
    if (hi[0] !== 2 * duty_of(13)) begin
      bad++;
      $display("FAIL indep_bit0: got %0d want %0d", hi[0], 2 * duty_of(13));
    end
    total++;
    if (hi[7] !== 2 * duty_of(14)) begin
      bad++;
      $display("FAIL indep_bit7: got %0d want %0d", hi[7], 2 * duty_of(14));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    e     = 0;
    test_reset();
    test_steady_on();
    test_linear_fade();
    test_retrigger();
    test_enable_blank();
    test_independent();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_fade_pwm.md
Name: led_fade_pwm

Overview:
- Downstream stage of the 8-bit LED flow generator; consumes its one-hot rotating pattern and drives the physical LED pins.
- Each channel gets a brightness level. The level jumps to full while its pattern bit is 1, then decays step by step after the bit clears. This gives a fading "comet tail" behind the moving LED.
- Brightness is realised by a shared free-running PWM counter compared against each channel's level.

Parameters:
- DUTY_W, 4, width of per-channel level and PWM counter; LVL_MAX = 2^DUTY_W-1.
- PWM_DIV, 24'd2500, sys_clk cycles per PWM tick (>=1).
- FADE_DIV, 16'd15, PWM ticks per fade step (>=1).

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst_n  input  1  synchronous reset, active-low.
- pwm_en  input  1  1 = run; 0 = blank outputs and clear state.
- led_in  input  8  LED pattern from the flow stage (led_out of flow_led).
- led_pwm  output  8  registered PWM drive to LED pins, active-high.

Behaviour:
- Reset (sys_rst_n=0 at a rising edge): led_pwm=0, all levels=0, pre_cnt=0, pwm_cnt=0, fade_cnt=0. Reset is synchronous only; no asynchronous path.
- Prescaler:
  - pre_cnt counts 0..PWM_DIV-1, then wraps.
  - pwm_tick=1 in the cycle where pre_cnt==PWM_DIV-1.
- PWM counter:
  - On pwm_tick, pwm_cnt counts 0..LVL_MAX-1, then wraps to 0.
  - PWM period is LVL_MAX ticks.
- Fade counter:
  - On pwm_tick, fade_cnt counts 0..FADE_DIV-1, then wraps.
  - fade_tick = pwm_tick && fade_cnt==FADE_DIV-1.
- Level update, per channel i, priority order:
  1. led_in[i]=1: level[i] <= LVL_MAX.
  2. Else if fade_tick and level[i]!=0: level[i] <= level[i]-1.
  3. Else: hold.
  - Decrement saturates at 0 and never wraps.
  - led_in[i]=1 coincident with fade_tick: load wins and level=LVL_MAX.
- Duty compare: led_pwm[i] <= (duty[i] > pwm_cnt), registered.
  - duty = level (no gamma).
  - level 0: always 0.
  - level LVL_MAX: always 1.
  - level L: high for L of every LVL_MAX ticks.
- Latency: led_in[i] sampled 1 at edge k gives level=LVL_MAX after edge k and led_pwm[i]=1 after edge k+1.
- Fade duration: a full fade from LVL_MAX to 0 takes LVL_MAX fade steps, i.e. LVL_MAX*FADE_DIV*PWM_DIV clocks, +/- one step of alignment.
- pwm_en=0 at an edge: led_pwm<=0, all levels<=0, all counters<=0. led_in is ignored while pwm_en=0.
- pwm_en 0->1: counters restart from 0, so timing is identical to post-reset.
- Multiple led_in bits may be 1 together; channels are fully independent.
- Reset mid-fade: everything returns to reset values on that edge.
- Counter widths: pre_cnt 24 bits, fade_cnt 16 bits, pwm_cnt DUTY_W bits; all comparisons are unsigned.

Optional Feature:
- Macro: LED_FADE_PWM_GAMMA_EN.
- Defined: duty[i] = (level==LVL_MAX) ? LVL_MAX : (level*level)>>DUTY_W. The product is 2*DUTY_W bits wide, which gives a perceptual fade curve.
  - For DUTY_W=4, levels 15..0 map to 15,12,10,9,7,6,5,4,3,2,1,1,0,0,0,0.
- Undefined: duty = level (linear). No multiplier logic is synthesised.

Test Plan:
- Bench config for all scenarios: DUTY_W=4, PWM_DIV=2, FADE_DIV=15, so one PWM period = 30 clocks = one fade step.
- Reset: led_in=8'hFF, sys_rst_n=0 for 3 edges -> led_pwm=8'h00 throughout; release -> led_pwm=8'hFF exactly 2 edges after first sampled edge.
- Steady on: led_in=8'h08 held, pwm_en=1 -> led_pwm[3]=1 in all 30 clocks of every period; other bits stay 0.
- Linear fade: led_in=8'h01 for 1 cycle then 8'h00 -> high clocks of led_pwm[0] per 30-clock period decrease by 2 each period (...,28,26,...,2,0); constant 0 within 16 periods; never re-rises.
- Retrigger collision: during fade, assert led_in[0]=1 on the cycle fade_tick fires -> next period led_pwm[0] high all 30 clocks (level 15, no decrement).
- Enable blanking: pwm_en=0 mid-fade with led_in=8'h81 -> led_pwm=8'h00 after next edge; pwm_en=1 with led_in=8'h00 -> led_pwm stays 8'h00.
- Gamma (LED_FADE_PWM_GAMMA_EN defined): after a single led_in[0] pulse, high clocks per period follow 2x the table: 30, 24, 20, 18, 14, 12, 10, 8, 6, 4, 2, 2, 0...
